// File: rtl/neuron_mac_seq.sv
// Single-neuron MAC sequencer: streams N_INPUTS signed (x,w) beats into a saturating
// 16-bit accumulator, adds a signed bias, optionally applies ReLU and hands off y.
module neuron_mac_seq #(
    parameter int N_INPUTS = 8,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [7:0]  bias,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  x,
    input  logic signed [7:0]  w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] y,
    output logic               ovf,
    output logic               busy
);

    localparam int CW = $clog2(N_INPUTS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_OUT
    } state_t;

    state_t             state, state_nxt;
    logic signed [15:0] acc, acc_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic signed [7:0]  bias_q, bias_nxt;
    logic               ovf_q, ovf_nxt;

    logic signed [15:0] prod;
    logic signed [15:0] addend;
    logic [16:0]        sum;
    logic               sat_ovf;
    logic signed [15:0] sat_val;

    // Shared adder: the product during ACCUM, the sign-extended bias during BIAS.
    // 16-bit operands make the 8x8 signed product exact (-16256..16384).
    always_comb begin
        prod    = 16'(x) * 16'(w);
        addend  = (state == S_BIAS) ? 16'(bias_q) : prod;
        sum     = {acc[15], acc} + {addend[15], addend};
        sat_ovf = sum[16] ^ sum[15];
        if (sat_ovf) begin
            sat_val = sum[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            sat_val = sum[15:0];
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        bias_nxt  = bias_q;
        ovf_nxt   = ovf_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    bias_nxt  = bias;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_nxt = sat_val;
                    ovf_nxt = ovf_q | sat_ovf;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        state_nxt = S_BIAS;
                    end
                end
            end
            S_BIAS: begin
                acc_nxt   = sat_val;
                ovf_nxt   = ovf_q | sat_ovf;
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            cnt    <= '0;
            bias_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            bias_q <= bias_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    // Handshake outputs decode state only, never the partner's valid/ready.
    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign ovf       = ovf_q;

    // acc keeps the pre-ReLU value; the clamp is applied only on the way out.
    always_comb begin
        y = '0;
        if (state == S_OUT) begin
            y = (RELU_EN && acc[15]) ? 16'sd0 : acc;
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: a ReLU and a pass-through instance share stimulus,
// an integer reference model pushes expected results, outputs are popped and compared.
module tb_neuron_mac_seq;

    localparam int N = 8;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [7:0]  bias;
    logic               in_valid;
    logic signed [7:0]  x;
    logic signed [7:0]  w;
    logic               out_ready;

    logic               in_ready_r, out_valid_r, ovf_r, busy_r;
    logic signed [15:0] y_r;
    logic               in_ready_n, out_valid_n, ovf_n, busy_n;
    logic signed [15:0] y_n;

    typedef struct {
        logic signed [15:0] y_relu;
        logic signed [15:0] y_raw;
        logic               ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    neuron_mac_seq #(.N_INPUTS(N), .RELU_EN(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_r), .x(x), .w(w),
        .out_valid(out_valid_r), .out_ready(out_ready), .y(y_r),
        .ovf(ovf_r), .busy(busy_r)
    );

    neuron_mac_seq #(.N_INPUTS(N), .RELU_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_n), .x(x), .w(w),
        .out_valid(out_valid_n), .out_ready(out_ready), .y(y_n),
        .ovf(ovf_n), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic with clamping after every addition.
    function automatic exp_t model(input logic signed [7:0] b,
                                   input logic signed [7:0] xs[N],
                                   input logic signed [7:0] ws[N]);
        exp_t e;
        int   a;
        bit   o;
        a = 0;
        o = 1'b0;
        for (int i = 0; i <= N; i++) begin
            if (i < N) a = a + int'(xs[i]) * int'(ws[i]);
            else       a = a + int'(b);
            if (a > 32767)  begin a = 32767;  o = 1'b1; end
            if (a < -32768) begin a = -32768; o = 1'b1; end
        end
        e.y_raw  = 16'(a);
        e.y_relu = (a < 0) ? 16'sd0 : 16'(a);
        e.ovf    = o;
        return e;
    endfunction

    task automatic do_start(input logic signed [7:0] b);
        start = 1'b1;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
        bias  = 8'sd0;
    endtask

    task automatic send_beats(input logic signed [7:0] xs[N],
                              input logic signed [7:0] ws[N],
                              input int gap, input int count);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            x = xs[i];
            w = ws[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            x = 8'sd0;
            w = 8'sd0;
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
        end
    endtask

    task automatic run(input logic signed [7:0] b,
                       input logic signed [7:0] xs[N],
                       input logic signed [7:0] ws[N],
                       input int gap);
        exp_q.push_back(model(b, xs, ws));
        do_start(b);
        send_beats(xs, ws, gap, N);
    endtask

    // Waits (bounded) for out_valid, pops the scoreboard and compares both instances.
    task automatic collect(input string name);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!out_valid_r && t < 40) begin
            @(negedge clk);
            t++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (!out_valid_r || !out_valid_n) begin
            $display("FAIL %s timeout: out_valid r=%b n=%b required 1", name, out_valid_r, out_valid_n);
        end else n_pass++;
        n_checks++;
        if (y_r !== e.y_relu) $display("FAIL %s y_relu: got %0d required %0d", name, y_r, e.y_relu);
        else n_pass++;
        n_checks++;
        if (y_n !== e.y_raw) $display("FAIL %s y_raw: got %0d required %0d", name, y_n, e.y_raw);
        else n_pass++;
        n_checks++;
        if (ovf_r !== e.ovf || ovf_n !== e.ovf)
            $display("FAIL %s ovf: got r=%b n=%b required %b", name, ovf_r, ovf_n, e.ovf);
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (busy_r !== 1'b0 || out_valid_r !== 1'b0)
            $display("FAIL %s return_idle: busy=%b out_valid=%b required 0/0", name, busy_r, out_valid_r);
        else n_pass++;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({in_ready_r, out_valid_r, busy_r, ovf_r, in_ready_n, out_valid_n, busy_n, ovf_n} !== 8'b0 ||
            y_r !== 16'sd0 || y_n !== 16'sd0)
            $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b ovf=%b y=%0d required all 0",
                     in_ready_r, out_valid_r, busy_r, ovf_r, y_r);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic signed [7:0] xs[N], ws[N];
        for (int i = 0; i < N; i++) begin xs[i] = 8'(i + 1); ws[i] = 8'sd1; end
        exp_q.push_back(model(8'sd0, xs, ws));
        do_start(8'sd0);
        send_beats(xs, ws, 0, N);
        // Just past the edge that took the 8th beat: BIAS cycle, no output yet.
        n_checks++;
        if (out_valid_r !== 1'b0 || in_ready_r !== 1'b0 || busy_r !== 1'b1)
            $display("FAIL latency_bias: out_valid=%b in_ready=%b busy=%b required 0/0/1",
                     out_valid_r, in_ready_r, busy_r);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_r !== 1'b1)
            $display("FAIL latency_out: out_valid=%b required 1", out_valid_r);
        else n_pass++;
        collect("basic");
    endtask

    task automatic test_saturation;
        logic signed [7:0] xs[N], ws[N];
        for (int i = 0; i < N; i++) begin xs[i] = 8'sd127; ws[i] = 8'sd127; end
        run(8'sd5, xs, ws, 0);
        collect("sat_pos");
        n_checks++;
        if (ovf_r !== 1'b1) $display("FAIL ovf_sticky_idle: got %b required 1", ovf_r);
        else n_pass++;
        for (int i = 0; i < N; i++) begin xs[i] = -8'sd128; ws[i] = 8'sd127; end
        exp_q.push_back(model(8'sd0, xs, ws));
        do_start(8'sd0);
        n_checks++;
        if (ovf_r !== 1'b0) $display("FAIL ovf_clear_on_start: got %b required 0", ovf_r);
        else n_pass++;
        send_beats(xs, ws, 0, N);
        collect("sat_neg");
    endtask

    task automatic test_relu;
        logic signed [7:0] xs[N], ws[N];
        for (int i = 0; i < N; i++) begin xs[i] = -8'sd10; ws[i] = 8'sd10; end
        run(-8'sd3, xs, ws, 0);
        collect("relu");
    endtask

    task automatic test_backpressure;
        logic signed [7:0] xs[N], ws[N];
        logic signed [15:0] y_hold;
        for (int i = 0; i < N; i++) begin xs[i] = 8'(3 - i); ws[i] = 8'(2 * i - 5); end
        exp_q.push_back(model(-8'sd20, xs, ws));
        do_start(-8'sd20);
        send_beats(xs, ws, 0, N);
        @(posedge clk); #1;
        y_hold = y_n;
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            @(negedge clk);
            n_checks++;
            if (out_valid_r !== 1'b1 || busy_r !== 1'b1 || y_n !== y_hold)
                $display("FAIL stall_%0d: out_valid=%b busy=%b y=%0d required 1/1/%0d",
                         c, out_valid_r, busy_r, y_n, y_hold);
            else n_pass++;
            @(posedge clk); #1;
        end
        // start held through the completing handshake must not launch a new inference.
        start = 1'b1;
        collect("backpressure");
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_r !== 1'b0) $display("FAIL start_at_out_ignored: busy=%b required 0", busy_r);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_gaps;
        logic signed [7:0] xs[N], ws[N];
        for (int i = 0; i < N; i++) begin xs[i] = 8'(i + 1); ws[i] = 8'sd1; end
        // Beats offered in IDLE must be ignored.
        in_valid = 1'b1;
        x = 8'sd100;
        w = 8'sd100;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy_r !== 1'b0 || in_ready_r !== 1'b0)
            $display("FAIL idle_beats: busy=%b in_ready=%b required 0/0", busy_r, in_ready_r);
        else n_pass++;
        in_valid = 1'b0;
        run(8'sd0, xs, ws, 2);
        collect("gaps");
    endtask

    task automatic test_abort;
        logic signed [7:0] xs[N], ws[N];
        for (int i = 0; i < N; i++) begin xs[i] = 8'sd100; ws[i] = 8'sd100; end
        do_start(8'sd7);
        send_beats(xs, ws, 0, 4);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (in_ready_r !== 1'b0 || out_valid_r !== 1'b0 || busy_r !== 1'b0 || ovf_r !== 1'b0 || y_r !== 16'sd0)
            $display("FAIL abort_outputs: rdy=%b vld=%b busy=%b ovf=%b y=%0d required all 0",
                     in_ready_r, out_valid_r, busy_r, ovf_r, y_r);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin xs[i] = 8'sd2; ws[i] = 8'sd3; end
        run(8'sd0, xs, ws, 0);
        collect("after_abort");
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bias      = 8'sd0;
        in_valid  = 1'b0;
        x         = 8'sd0;
        w         = 8'sd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_backpressure();
        test_gaps();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
